bcd_mod_counter: RTL and testbench
==================================

# bcd_mod_counter

Parametrised, clocked modulo counter for the digital-clock datapath: counts from MIN_VAL to MAX_VAL and wraps, up or down, advancing only on a carry-in strobe. It provides a binary value, a two-digit BCD view for the display decoders, and a same-cycle carry/borrow out for cascading. Seconds, minutes and hours (0–23 or 1–12) are all built from this one block, and the time-set path uses its synchronous load.

## Interface
- WIDTH, 7: binary count width; requires 2^WIDTH > MAX_VAL.
- MIN_VAL, 0: lowest count value; also the up-count wrap target.
- MAX_VAL, 59: highest count value, ≤ 99; also the down-count wrap target.
- RST_VAL, MIN_VAL: value after reset; must lie in [MIN_VAL, MAX_VAL].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- carry_in  in  1  count strobe, one clk cycle wide (prescaler tick or previous stage's carry_out).
- up_dn  in  1  1 = count up, 0 = count down; sampled only when a step occurs.
- load  in  1  synchronous load request.
- load_val  in  WIDTH  binary value to load.
- count  out  WIDTH  registered binary count.
- bcd_tens  out  4  tens digit of count, 0–9.
- bcd_ones  out  4  ones digit of count, 0–9.
- carry_out  out  1  combinational wrap strobe for the next stage.
- load_err  out  1  registered one-cycle flag: the last load request was rejected.

## Operation
- Priority per clock edge: rst > load > carry_in.
- rst: count ← RST_VAL, load_err ← 0.
- load with MIN_VAL ≤ load_val ≤ MAX_VAL: count ← load_val, load_err ← 0.
- load with load_val out of range: count holds, load_err ← 1 for exactly one cycle.
- No load, carry_in = 1, up_dn = 1: if count == MAX_VAL then count ← MIN_VAL, otherwise count ← count + 1.
- No load, carry_in = 1, up_dn = 0: if count == MIN_VAL then count ← MAX_VAL, otherwise count ← count − 1.
- carry_in = 0 and no load: count holds.
- load_err clears on the next edge that has no rejected load.
- carry_out = carry_in & ~load & ~rst & (up_dn ? count == MAX_VAL : count == MIN_VAL).
- Cascading: a chain of stages all step on the same edge. No combinational path from carry_out back into the same stage.
- BCD conversion is combinational from the registered count: bcd_tens = count / 10, bcd_ones = count % 10. Only values 0–99 are needed.
- All comparisons are unsigned and at WIDTH bits. No arithmetic overflow is possible, because wrap is decided by the compare, not by the adder.

## Timing
- Reset values: count = RST_VAL, load_err = 0, carry_out = 0; BCD outputs show RST_VAL.
- Step latency: count changes on the edge where carry_in = 1 is sampled and is visible 1 cycle later.
- carry_out: valid in the same cycle as carry_in, zero latency, so a downstream stage steps on the same edge.
- Load latency: 1 cycle. A load asserted together with carry_in suppresses both the step and carry_out.
- rst asserted mid-count or during a load: rst wins; the next cycle shows RST_VAL.
- up_dn changing between strobes: allowed; only its value at a strobe edge matters.
- carry_in held high for several cycles: steps on every cycle (testing fast-forward); carry_out pulses on each wrap.

## Structure
- Shared package `clock_pkg` holds the constants SEC_MAX = 59, MIN_MAX = 59, HR24_MAX = 23, HR12_MIN = 1, HR12_MAX = 12.
- The package also holds a `bcd2_t` typedef: a struct of the two 4-bit digits.
- One sub-module, `bin_to_bcd2`: a combinational 0–99 binary-to-two-digit-BCD converter, reused by the display path.
- Elaboration-time checks: MIN_VAL ≤ RST_VAL ≤ MAX_VAL ≤ 99, and MAX_VAL < 2^WIDTH.

## Test plan
- Default (0–59), carry_in every cycle: count 58 → 59 with carry_out = 1 while at 59, then 0; BCD reads 5/9 at 59, then 0/0.
- MIN_VAL = 1, MAX_VAL = 12, RST_VAL = 12: reset → 12 (BCD 1/2); one strobe → 1; down-strobe at 1 → 12 with carry_out = 1.
- Load 75 on the default instance: count holds, load_err = 1 for one cycle then 0. Load 30: count = 30 next cycle, BCD 3/0.
- load and carry_in together at count = 59: count = load_val, carry_out = 0.
- Three-stage cascade (sec 0–59, min 0–59, hr 0–23) preloaded to 23:59:59, one tick: all three stages wrap to 00:00:00 on the same edge.
- rst asserted during a strobe at count = 40: count = RST_VAL next cycle, carry_out = 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and types for the digital-clock datapath.
// Every counter stage and the display decoders import this package.
package clock_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MIN = 1;
    localparam int HR12_MAX = 12;
    localparam int BCD2_MAX = 99;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

endpackage

// File: rtl/bin_to_bcd2.sv
// Combinational binary (0-99) to two-digit BCD converter, shared with the display path.
// Inputs above 99 produce undefined digits; no caller drives them.
module bin_to_bcd2
    import clock_pkg::*;
(
    input  logic [6:0] i_bin,
    output bcd2_t      o_bcd
);

    always_comb begin
        o_bcd      = '0;
        o_bcd.tens = 4'(i_bin / 7'd10);
        o_bcd.ones = 4'(i_bin % 7'd10);
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Modulo MIN_VAL..MAX_VAL up/down counter stepping on carry_in, with synchronous load,
// two-digit BCD view and a same-cycle carry/borrow out for cascading stages.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int WIDTH   = 7,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59,
    parameter int RST_VAL = MIN_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carry_in,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             carry_out,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

    if (!(MIN_VAL >= 0 && MIN_VAL <= RST_VAL && RST_VAL <= MAX_VAL && MAX_VAL <= BCD2_MAX))
    begin : g_bad_range
        $error("bcd_mod_counter: need 0 <= MIN_VAL <= RST_VAL <= MAX_VAL <= 99");
    end
    if (WIDTH < 1 || WIDTH > 30 || MAX_VAL >= (2 ** WIDTH)) begin : g_bad_width
        $error("bcd_mod_counter: MAX_VAL must fit in WIDTH bits");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_load_err;
    logic             w_ge_min;
    logic             w_load_ok;
    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_step_val;
    bcd2_t            w_bcd;

    // A zero lower bound makes the compare trivially true; keep it out of the netlist.
    if (MIN_VAL == 0) begin : g_min_zero
        assign w_ge_min = 1'b1;
    end else begin : g_min_cmp
        assign w_ge_min = (load_val >= MIN_W);
    end

    assign w_load_ok = w_ge_min && (load_val <= MAX_W);
    assign w_at_max  = (r_count == MAX_W);
    assign w_at_min  = (r_count == MIN_W);

    // Wrap is decided by the compare, so the adder never overflows.
    always_comb begin
        w_step_val = r_count;
        if (up_dn) begin
            w_step_val = w_at_max ? MIN_W : r_count + WIDTH'(1);
        end else begin
            w_step_val = w_at_min ? MAX_W : r_count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= RST_W;
            r_load_err <= 1'b0;
        end else if (load) begin
            if (w_load_ok) begin
                r_count <= load_val;
            end
            r_load_err <= ~w_load_ok;
        end else begin
            r_load_err <= 1'b0;
            if (carry_in) begin
                r_count <= w_step_val;
            end
        end
    end

    assign carry_out = carry_in & ~load & ~rst & (up_dn ? w_at_max : w_at_min);

    bin_to_bcd2 u_bcd (
        .i_bin (7'(r_count)),
        .o_bcd (w_bcd)
    );

    assign count    = r_count;
    assign bcd_tens = w_bcd.tens;
    assign bcd_ones = w_bcd.ones;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench: default 0-59 stage from a vector table, a 1-12 hour stage,
// and a sec/min/hr24 cascade wrapping 23:59:59 to 00:00:00.
module tb_bcd_mod_counter;
    import clock_pkg::*;

    typedef struct {
        logic       rst;
        logic       load;
        logic       ci;
        logic       up;
        logic [6:0] lv;
        logic       exp_co;
        logic [6:0] exp_cnt;
        logic [3:0] exp_tens;
        logic [3:0] exp_ones;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // default stage (0..59)
    logic       rst0 = 1'b1, ci0 = 1'b0, up0 = 1'b1, load0 = 1'b0;
    logic [6:0] lv0 = '0, cnt0;
    logic [3:0] tens0, ones0;
    logic       co0, err0;

    // 12-hour stage (1..12, resets to 12)
    logic       rst_b = 1'b1;
    logic       ci_h = 1'b0, up_h = 1'b1, load_h = 1'b0;
    logic [3:0] lv_h = '0, cnt_h;
    logic [3:0] tens_h, ones_h;
    logic       co_h, err_h;

    // cascade
    logic       tick = 1'b0, up_c = 1'b1, load_c = 1'b0;
    logic [5:0] lv_s = '0, lv_m = '0, cnt_s, cnt_m;
    logic [4:0] lv_hr = '0, cnt_hr;
    logic [3:0] ts, os, tm, om, thr, ohr;
    logic       co_s, co_m, co_hr, err_s, err_m, err_hr;

    bcd_mod_counter dut0 (
        .clk(clk), .rst(rst0), .carry_in(ci0), .up_dn(up0), .load(load0), .load_val(lv0),
        .count(cnt0), .bcd_tens(tens0), .bcd_ones(ones0), .carry_out(co0), .load_err(err0)
    );

    bcd_mod_counter #(.WIDTH(4), .MIN_VAL(HR12_MIN), .MAX_VAL(HR12_MAX), .RST_VAL(HR12_MAX)) dut_h12 (
        .clk(clk), .rst(rst_b), .carry_in(ci_h), .up_dn(up_h), .load(load_h), .load_val(lv_h),
        .count(cnt_h), .bcd_tens(tens_h), .bcd_ones(ones_h), .carry_out(co_h), .load_err(err_h)
    );

    bcd_mod_counter #(.WIDTH(6), .MAX_VAL(SEC_MAX)) dut_sec (
        .clk(clk), .rst(rst_b), .carry_in(tick), .up_dn(up_c), .load(load_c), .load_val(lv_s),
        .count(cnt_s), .bcd_tens(ts), .bcd_ones(os), .carry_out(co_s), .load_err(err_s)
    );

    bcd_mod_counter #(.WIDTH(6), .MAX_VAL(MIN_MAX)) dut_min (
        .clk(clk), .rst(rst_b), .carry_in(co_s), .up_dn(up_c), .load(load_c), .load_val(lv_m),
        .count(cnt_m), .bcd_tens(tm), .bcd_ones(om), .carry_out(co_m), .load_err(err_m)
    );

    bcd_mod_counter #(.WIDTH(5), .MAX_VAL(HR24_MAX)) dut_hr (
        .clk(clk), .rst(rst_b), .carry_in(co_m), .up_dn(up_c), .load(load_c), .load_val(lv_hr),
        .count(cnt_hr), .bcd_tens(thr), .bcd_ones(ohr), .carry_out(co_hr), .load_err(err_hr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int rst, input int load, input int ci, input int up,
                                input int lv, input int co, input int cnt, input int err);
        vec_t v;
        v.rst      = 1'(rst);
        v.load     = 1'(load);
        v.ci       = 1'(ci);
        v.up       = 1'(up);
        v.lv       = 7'(lv);
        v.exp_co   = 1'(co);
        v.exp_cnt  = 7'(cnt);
        v.exp_tens = 4'(cnt / 10);
        v.exp_ones = 4'(cnt % 10);
        v.exp_err  = 1'(err);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[18];

    initial begin
        //              rst ld ci up  lv  co cnt err
        vecs[0]  = mk(1, 0, 0, 1,  0, 0,  0, 0);
        vecs[1]  = mk(0, 1, 0, 1, 58, 0, 58, 0);
        vecs[2]  = mk(0, 0, 1, 1,  0, 0, 59, 0);
        vecs[3]  = mk(0, 0, 1, 1,  0, 1,  0, 0);
        vecs[4]  = mk(0, 0, 1, 0,  0, 1, 59, 0);
        vecs[5]  = mk(0, 1, 0, 1, 75, 0, 59, 1);
        vecs[6]  = mk(0, 0, 0, 1,  0, 0, 59, 0);
        vecs[7]  = mk(0, 1, 0, 1, 30, 0, 30, 0);
        vecs[8]  = mk(0, 0, 1, 0,  0, 0, 29, 0);
        vecs[9]  = mk(0, 1, 0, 1, 59, 0, 59, 0);
        vecs[10] = mk(0, 1, 1, 1, 12, 0, 12, 0);
        vecs[11] = mk(0, 1, 0, 1, 40, 0, 40, 0);
        vecs[12] = mk(1, 0, 1, 1,  0, 0,  0, 0);
        vecs[13] = mk(0, 0, 1, 1,  0, 0,  1, 0);
        vecs[14] = mk(0, 1, 0, 1, 60, 0,  1, 1);
        vecs[15] = mk(0, 1, 1, 1, 99, 0,  1, 1);
        vecs[16] = mk(0, 1, 0, 1,  0, 0,  0, 0);
        vecs[17] = mk(0, 0, 0, 0,  0, 0,  0, 0);

        // reset state of every instance
        #1;
        chk("reset_co0", 32'(co0), 0);
        step();
        chk("reset_cnt0", 32'(cnt0), 0);
        chk("reset_err0", 32'(err0), 0);
        chk("reset_cnt_h12", 32'(cnt_h), 12);
        chk("reset_tens_h12", 32'(tens_h), 1);
        chk("reset_ones_h12", 32'(ones_h), 2);
        chk("reset_cnt_sec", 32'(cnt_s), 0);
        rst_b = 1'b0;

        for (int i = 0; i < 18; i++) begin
            rst0  = vecs[i].rst;
            load0 = vecs[i].load;
            ci0   = vecs[i].ci;
            up0   = vecs[i].up;
            lv0   = vecs[i].lv;
            #1;
            chk($sformatf("v%0d_co", i), 32'(co0), 32'(vecs[i].exp_co));
            step();
            chk($sformatf("v%0d_cnt", i), 32'(cnt0), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_tens", i), 32'(tens0), 32'(vecs[i].exp_tens));
            chk($sformatf("v%0d_ones", i), 32'(ones0), 32'(vecs[i].exp_ones));
            chk($sformatf("v%0d_err", i), 32'(err0), 32'(vecs[i].exp_err));
        end
        rst0 = 1'b0; load0 = 1'b0; ci0 = 1'b0;

        // 12-hour stage: up wrap 12 -> 1, down wrap 1 -> 12, reject load below MIN_VAL
        ci_h = 1'b1; up_h = 1'b1;
        #1 chk("h12_up_co", 32'(co_h), 1);
        step();
        chk("h12_up_cnt", 32'(cnt_h), 1);
        up_h = 1'b0;
        #1 chk("h12_dn_co", 32'(co_h), 1);
        step();
        chk("h12_dn_cnt", 32'(cnt_h), 12);
        chk("h12_dn_tens", 32'(tens_h), 1);
        ci_h = 1'b0; load_h = 1'b1; lv_h = 4'd0;
        step();
        chk("h12_ld0_err", 32'(err_h), 1);
        chk("h12_ld0_cnt", 32'(cnt_h), 12);
        load_h = 1'b0;
        step();
        chk("h12_err_clr", 32'(err_h), 0);

        // cascade: preload 23:59:59, one tick wraps all stages on the same edge
        load_c = 1'b1; lv_s = 6'd59; lv_m = 6'd59; lv_hr = 5'd23;
        step();
        load_c = 1'b0;
        chk("casc_pre", 32'({cnt_hr, cnt_m, cnt_s}), 32'({5'd23, 6'd59, 6'd59}));
        tick = 1'b1;
        #1;
        chk("casc_co_s", 32'(co_s), 1);
        chk("casc_co_m", 32'(co_m), 1);
        chk("casc_co_hr", 32'(co_hr), 1);
        step();
        tick = 1'b0;
        chk("casc_wrap", 32'({cnt_hr, cnt_m, cnt_s}), 0);
        chk("casc_bcd", 32'({thr, ohr, tm, om, ts, os}), 0);
        chk("casc_err", 32'({err_hr, err_m, err_s}), 0);
        tick = 1'b1;
        #1 chk("casc_co_m_idle", 32'(co_m), 0);
        step();
        tick = 1'b0;
        chk("casc_next", 32'({cnt_hr, cnt_m, cnt_s}), 32'({5'd0, 6'd0, 6'd1}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
